// File: rtl/demod_pkg.sv
// rtl/demod_pkg.sv - shared types and Q16.16 constants for the demodulation pipe
package demod_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        DECIDE = 2'd2
    } demod_state_t;

    localparam logic [31:0] Q_ONE   = 32'h0001_0000;
    localparam logic [31:0] Q_MONE  = 32'hFFFF_0000;
    localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/sat_narrow.sv
// rtl/sat_narrow.sv - combinational signed saturating narrowing from IN_W to OUT_W bits
module sat_narrow #(
    parameter int IN_W  = 36,
    parameter int OUT_W = 32
) (
    input  logic signed [IN_W-1:0]  i_din,
    output logic signed [OUT_W-1:0] o_dout
);

    // The value fits iff every bit from the output sign bit upward agrees.
    logic [IN_W-OUT_W:0] w_upper;
    assign w_upper = i_din[IN_W-1:OUT_W-1];

    always_comb begin
        o_dout = i_din[OUT_W-1:0];
        if (!((&w_upper) || !(|w_upper))) begin
            if (i_din[IN_W-1]) begin
                o_dout = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                o_dout = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/demod_bit_decide.sv
// rtl/demod_bit_decide.sv - sums N_SEG segment correlations into a saturated soft metric and hard bit
module demod_bit_decide
    import demod_pkg::*;
#(
    parameter int N_SEG = 10,
    parameter int W     = 32
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic signed [W-1:0] i_seg_in,
    input  logic                i_seg_valid,
    output logic                o_bit_out,
    output logic [W-1:0]        o_metric,
    output logic                o_valid,
    output logic                o_busy
);

    localparam int ACC_W = W + 4;
    localparam int CNT_W = $clog2(N_SEG);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SEG - 1);

    demod_state_t            r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_bit_out;
    logic [W-1:0]            r_metric;
    logic                    r_valid;
    logic                    r_busy;

    logic signed [ACC_W-1:0] w_seg_ext;
    logic signed [W-1:0]     w_sat;

    assign w_seg_ext = {{(ACC_W-W){i_seg_in[W-1]}}, i_seg_in};

    sat_narrow #(
        .IN_W  (ACC_W),
        .OUT_W (W)
    ) u_sat_narrow (
        .i_din  (r_acc),
        .o_dout (w_sat)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_bit_out <= 1'b0;
            r_metric  <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (i_seg_valid) begin
                        r_acc <= r_acc + w_seg_ext;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST_CNT) begin
                            r_state <= DECIDE;
                        end
                    end
                end
                DECIDE: begin
                    // A zero sum is a tie and resolves to 0, same as negative.
                    r_bit_out <= (r_acc > 0);
                    r_metric  <= w_sat;
                    r_valid   <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_bit_out = r_bit_out;
    assign o_metric  = r_metric;
    assign o_valid   = r_valid;
    assign o_busy    = r_busy;

endmodule

// File: tb/tb_demod_bit_decide.sv
// tb/tb_demod_bit_decide.sv - scoreboard bench for demod_bit_decide
module tb_demod_bit_decide;

    typedef struct {
        logic        b;
        logic [31:0] m;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] seg_in;
    logic        seg_valid;
    logic        bit_out;
    logic [31:0] metric;
    logic        valid;
    logic        busy;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   valid_cnt = 0;
    int   last_valid_cyc = 0;
    int   start_cyc = 0;
    int   start_vcnt = 0;
    logic prev_valid = 1'b0;

    demod_bit_decide #(
        .N_SEG (10),
        .W     (32)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_start     (start),
        .i_seg_in    (seg_in),
        .i_seg_valid (seg_valid),
        .o_bit_out   (bit_out),
        .o_metric    (metric),
        .o_valid     (valid),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every valid pulse pops one expected result.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (valid) begin
            n_checks++;
            if (prev_valid) $display("FAIL valid_width: valid high two cycles in a row");
            else n_pass++;
            valid_cnt++;
            last_valid_cyc = cyc;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_valid: got valid with metric=%h, expected no result", metric);
            end else begin
                e = exp_q.pop_front();
                if (metric !== e.m || bit_out !== e.b)
                    $display("FAIL result: got bit=%b metric=%h, expected bit=%b metric=%h",
                             bit_out, metric, e.b, e.m);
                else n_pass++;
            end
            n_checks++;
            if (busy !== 1'b0) $display("FAIL busy_with_valid: got busy=%b, expected 0", busy);
            else n_pass++;
        end
        prev_valid = valid;
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cyc  = cyc;
        start_vcnt = valid_cnt;
    endtask

    task automatic send(input logic [31:0] v);
        seg_in    = v;
        seg_valid = 1'b1;
        @(negedge clk);
        seg_valid = 1'b0;
        seg_in    = '0;
    endtask

    task automatic wait_valid(input string name, input int exp_lat);
        int k;
        for (k = 0; k < 60 && valid_cnt == start_vcnt; k++) @(negedge clk);
        n_checks++;
        if (valid_cnt == start_vcnt)
            $display("FAIL %s_timeout: no valid within 60 cycles, expected latency %0d", name, exp_lat);
        else if (last_valid_cyc - start_cyc != exp_lat)
            $display("FAIL %s_latency: got %0d edges, expected %0d", name, last_valid_cyc - start_cyc, exp_lat);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; seg_in = '0; seg_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bit_out, metric, valid, busy} !== 35'd0)
            $display("FAIL reset_outputs: got bit=%b metric=%h valid=%b busy=%b, expected all 0",
                     bit_out, metric, valid, busy);
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bit_out, metric, valid, busy} !== 35'd0)
            $display("FAIL post_reset_idle: got bit=%b metric=%h valid=%b busy=%b, expected all 0",
                     bit_out, metric, valid, busy);
        else n_pass++;
    endtask

    task automatic test_nominal();
        exp_q.push_back('{1'b1, 32'h000A_0000});
        do_start();
        n_checks++;
        if (busy !== 1'b1) $display("FAIL busy_after_start: got %b, expected 1", busy);
        else n_pass++;
        for (int i = 0; i < 10; i++) send(32'h0001_0000);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL busy_in_decide: got %b, expected 1", busy);
        else n_pass++;
        wait_valid("nominal", 11);
    endtask

    task automatic test_neg_gaps();
        exp_q.push_back('{1'b0, 32'hFFF6_0000});
        do_start();
        for (int i = 0; i < 4; i++) send(32'hFFFF_0000);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) send(32'hFFFF_0000);
        wait_valid("neg_gaps", 14);
    endtask

    task automatic test_tie();
        exp_q.push_back('{1'b0, 32'h0000_0000});
        do_start();
        for (int i = 0; i < 5; i++) begin
            send(32'h0001_0000);
            send(32'hFFFF_0000);
        end
        wait_valid("tie", 11);
    endtask

    task automatic test_saturation();
        exp_q.push_back('{1'b1, 32'h7FFF_FFFF});
        do_start();
        for (int i = 0; i < 10; i++) send(32'h7FFF_FFFF);
        wait_valid("sat_pos", 11);
        @(negedge clk);
        exp_q.push_back('{1'b0, 32'h8000_0000});
        do_start();
        for (int i = 0; i < 10; i++) send(32'h8000_0000);
        wait_valid("sat_neg", 11);
    endtask

    task automatic test_handshake_abuse();
        int vc;
        @(negedge clk);
        vc = valid_cnt;
        for (int i = 0; i < 3; i++) send(32'h0005_0000);
        repeat (3) @(negedge clk);
        n_checks++;
        if (valid_cnt != vc || busy !== 1'b0 || metric !== 32'h8000_0000)
            $display("FAIL idle_seg_valid: got valids=%0d busy=%b metric=%h, expected 0 new, busy 0, metric 80000000",
                     valid_cnt - vc, busy, metric);
        else n_pass++;
        exp_q.push_back('{1'b1, 32'h000A_0000});
        do_start();
        for (int i = 0; i < 5; i++) send(32'h0001_0000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) send(32'h0001_0000);
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b1) $display("FAIL valid_cycle: got valid=%b, expected 1", valid);
        else n_pass++;
        n_checks++;
        if (last_valid_cyc - start_cyc != 12)
            $display("FAIL abuse_latency: got %0d edges, expected 12", last_valid_cyc - start_cyc);
        else n_pass++;
        exp_q.push_back('{1'b0, 32'hFFF6_0000});
        do_start();
        n_checks++;
        if (busy !== 1'b1) $display("FAIL start_in_valid: got busy=%b, expected 1", busy);
        else n_pass++;
        for (int i = 0; i < 10; i++) send(32'hFFFF_0000);
        wait_valid("back_to_back", 11);
    endtask

    task automatic test_reset_mid();
        int vc;
        @(negedge clk);
        do_start();
        for (int i = 0; i < 6; i++) send(32'h0003_0000);
        vc = valid_cnt;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bit_out, metric, valid, busy} !== 35'd0)
            $display("FAIL reset_mid: got bit=%b metric=%h valid=%b busy=%b, expected all 0",
                     bit_out, metric, valid, busy);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        n_checks++;
        if (valid_cnt != vc) $display("FAIL aborted_valid: got %0d valids, expected 0", valid_cnt - vc);
        else n_pass++;
        exp_q.push_back('{1'b1, 32'h0014_0000});
        do_start();
        for (int i = 0; i < 10; i++) send(32'h0002_0000);
        wait_valid("after_reset", 11);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_neg_gaps();
        test_tie();
        test_saturation();
        test_handshake_abuse();
        test_reset_mid();
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
